axis_frame_gen: RTL and testbench

- AXI4-Stream video source (master) that generates synthetic RGB frames to feed the denoise pipeline's s_curr/s_prev slave inputs.
- Emits tuser on the first pixel of each frame (SOF) and tlast on the last pixel of each line (EOL).
- Honours tready backpressure.
- Supplies bring-up and regression stimulus in place of the camera/VDMA path.

---
 rtl/axis_video_pkg.sv | 86 ++++++++
 rtl/prbs16_lfsr.sv | 23 ++
 rtl/axis_frame_gen.sv | 261 ++++++++++++++++++++++++++
 tb/tb_axis_frame_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_video_pkg.sv
// Shared definitions for the synthetic AXI4-Stream video source: pattern codes,
// FSM state encoding, colour-bar palette, default frame geometry and the noise
// LFSR step function.
package axis_video_pkg;

  // Default frame geometry (1080p active area).
  localparam int unsigned DEF_H_RES = 1920;
  localparam int unsigned DEF_V_RES = 1080;

  // Test pattern codes driven on pattern_sel.
  localparam logic [1:0] PAT_GRAY  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_BARS  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  // Generator FSM state encoding.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ACTIVE    = 2'd1;
  localparam logic [1:0] ST_LINE_GAP  = 2'd2;
  localparam logic [1:0] ST_FRAME_GAP = 2'd3;

  // Colour bars, left to right, as {R, G, B}.
  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Constant fill levels.
  localparam logic [31:0] PIX_GRAY  = 32'h0080_8080;
  localparam logic [31:0] PIX_WHITE = 32'h00FF_FFFF;
  localparam logic [31:0] PIX_BLACK = 32'h0000_0000;

  // Noise generator reset value.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Per-run configuration captured at every frame start.
  typedef struct packed {
    logic [1:0]  pattern;
    logic [7:0]  line_gap;
    logic [15:0] frame_gap;
    logic [15:0] frame_count;
  } gen_cfg_t;

  // Bar index to {R, G, B} colour.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

  // Clean pixel word {8'h00, R, G, B} for a pattern at the given position.
  function automatic logic [31:0] pattern_pixel(input logic [1:0] pat,
                                                input logic [7:0] x_lo,
                                                input logic       chk,
                                                input logic [2:0] bar);
    logic [31:0] p;
    case (pat)
      PAT_GRAY: p = PIX_GRAY;
      PAT_RAMP: p = {8'h00, x_lo, x_lo, x_lo};
      PAT_BARS: p = {8'h00, bar_color(bar)};
      default:  p = chk ? PIX_WHITE : PIX_BLACK;
    endcase
    return p;
  endfunction

  // One step of the x^16+x^14+x^13+x^11+1 Fibonacci register (right shifting).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/prbs16_lfsr.sv
// 16-bit Fibonacci PRBS used as the pixel-noise source; reloads SEED on reset
// and advances once per cycle while enable is high.
module prbs16_lfsr
  import axis_video_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  output logic [15:0] state
);

  // Shift register with synchronous seed reload.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= SEED;
    end else if (enable) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/axis_frame_gen.sv
// Synthetic RGB frame source on an AXI4-Stream master port. Emits tuser on the
// first pixel of a frame and tlast on the last pixel of each line, honours
// tready, and inserts programmable idle gaps between lines and frames.
// Optional pixel noise is built only when AXIS_FRAME_GEN_NOISE_EN is defined.
module axis_frame_gen
  import axis_video_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned H_RES      = DEF_H_RES,
  parameter int unsigned V_RES      = DEF_V_RES
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [15:0]           frame_count,
  input  logic [7:0]            line_gap,
  input  logic [15:0]           frame_gap,
  input  logic                  noise_en,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frames_sent
);

  localparam int unsigned XW    = $clog2(H_RES);
  localparam int unsigned YW    = $clog2(V_RES);
  localparam int unsigned BAR_W = H_RES / 8;
  localparam int unsigned BW    = $clog2(BAR_W);

  localparam logic [XW-1:0] X_LAST   = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_RES - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [1:0]            state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [BW-1:0]         pos_q, pos_d;
  logic [2:0]            bar_q, bar_d;
  gen_cfg_t              cfg_q, cfg_d;
  logic [15:0]           gap_q, gap_d;
  logic [15:0]           fs_d;
  logic [DATA_WIDTH-1:0] tdata_d;
  logic                  tvalid_d, tlast_d, tuser_d, busy_d, frame_done_d;

  logic                  accept;
  logic [15:0]           fs_inc;
  logic                  more_now;
  logic                  more_after;
  logic [31:0]           noise_mask;

  logic                  start;
  logic                  stop;
  logic                  load;
  logic [1:0]            pat_use;
  logic                  chk;

  assign accept = m_axis_tvalid && m_axis_tready;

  // Saturating completed-frame count and the continue-run decision before and
  // after counting the frame that is completing now.
  assign fs_inc     = (frames_sent == 16'hFFFF) ? frames_sent : frames_sent + 16'd1;
  assign more_now   = enable && ((cfg_q.frame_count == 16'd0) ||
                                 (frames_sent < cfg_q.frame_count));
  assign more_after = enable && ((cfg_q.frame_count == 16'd0) ||
                                 (fs_inc < cfg_q.frame_count));

`ifdef AXIS_FRAME_GEN_NOISE_EN
  logic [15:0] lfsr_q;
  logic [8:0]  lfsr_now;

  prbs16_lfsr #(
    .SEED   (LFSR_SEED)
  ) u_lfsr (
    .aclk   (aclk),
    .areset (areset),
    .enable (accept),
    .state  (lfsr_q)
  );

  // A pixel loaded alongside an acceptance sees the post-advance LFSR value,
  // so beat n is always perturbed by the state after n accepted beats.
  assign lfsr_now   = 9'(accept ? lfsr_step(lfsr_q) : lfsr_q);
  assign noise_mask = noise_en ? {8'h00, 5'h00, lfsr_now[8:6],
                                         5'h00, lfsr_now[5:3],
                                         5'h00, lfsr_now[2:0]} : 32'h0;
`else
  logic unused_noise_en;
  assign unused_noise_en = noise_en;
  assign noise_mask      = 32'h0;
`endif

  // Next-state, position, configuration and output computation.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    pos_d        = pos_q;
    bar_d        = bar_q;
    cfg_d        = cfg_q;
    gap_d        = gap_q;
    fs_d         = frames_sent;
    tdata_d      = m_axis_tdata;
    tvalid_d     = m_axis_tvalid;
    tlast_d      = m_axis_tlast;
    tuser_d      = m_axis_tuser;
    frame_done_d = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    load         = 1'b0;
    pat_use      = cfg_q.pattern;
    chk          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          start = 1'b1;
          fs_d  = 16'd0;
        end
      end

      ST_ACTIVE: begin
        if (accept) begin
          if (x_q == X_LAST) begin
            x_d   = '0;
            pos_d = '0;
            bar_d = 3'd0;
            if (y_q == Y_LAST) begin
              y_d          = '0;
              frame_done_d = 1'b1;
              fs_d         = fs_inc;
              if (cfg_q.frame_gap != 16'd0) begin
                state_d = ST_FRAME_GAP;
                gap_d   = cfg_q.frame_gap;
                stop    = 1'b1;
              end else if (more_after) begin
                start = 1'b1;
              end else begin
                state_d = ST_IDLE;
                stop    = 1'b1;
              end
            end else begin
              y_d = y_q + YW'(1);
              if (cfg_q.line_gap != 8'd0) begin
                state_d = ST_LINE_GAP;
                gap_d   = 16'(cfg_q.line_gap);
                stop    = 1'b1;
              end else begin
                load = 1'b1;
              end
            end
          end else begin
            x_d = x_q + XW'(1);
            if (pos_q == BAR_LAST) begin
              pos_d = '0;
              bar_d = bar_q + 3'd1;
            end else begin
              pos_d = pos_q + BW'(1);
            end
            load = 1'b1;
          end
        end
      end

      ST_LINE_GAP: begin
        if (gap_q == 16'd1) begin
          state_d = ST_ACTIVE;
          load    = 1'b1;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end

      ST_FRAME_GAP: begin
        if (gap_q == 16'd1) begin
          if (more_now) begin
            start = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        stop    = 1'b1;
      end
    endcase

    // A new frame restarts at the origin with freshly captured configuration.
    if (start) begin
      state_d = ST_ACTIVE;
      cfg_d   = {pattern_sel, line_gap, frame_gap, frame_count};
      pat_use = pattern_sel;
      x_d     = '0;
      y_d     = '0;
      pos_d   = '0;
      bar_d   = 3'd0;
      load    = 1'b1;
    end

    if (stop) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tuser_d  = 1'b0;
    end

    // Present the pixel at the (new) position.
    if (load) begin
      chk      = 1'((16'(x_d) >> 4) ^ (16'(y_d) >> 4));
      tvalid_d = 1'b1;
      tdata_d  = DATA_WIDTH'(pattern_pixel(pat_use, 8'(x_d), chk, bar_d) ^ noise_mask);
      tuser_d  = (x_d == '0) && (y_d == '0);
      tlast_d  = (x_d == X_LAST);
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and registered-output update with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      pos_q         <= '0;
      bar_q         <= 3'd0;
      cfg_q         <= '0;
      gap_q         <= 16'd0;
      frames_sent   <= 16'd0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pos_q         <= pos_d;
      bar_q         <= bar_d;
      cfg_q         <= cfg_d;
      gap_q         <= gap_d;
      frames_sent   <= fs_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tlast  <= tlast_d;
      m_axis_tuser  <= tuser_d;
      busy          <= busy_d;
      frame_done    <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen with a 16x4 frame. A beat-indexed
// reference model derives every expected pixel, gap and status value from the
// frame geometry; tready is driven steady, toggling or random.
module tb_axis_frame_gen;

  localparam int H_RES = 16;
  localparam int V_RES = 4;
  localparam int FRAME = H_RES * V_RES;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        aclk;
  logic        areset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] frame_count;
  logic [7:0]  line_gap;
  logic [15:0] frame_gap;
  logic        noise_en;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        busy;
  logic        frame_done;
  logic [15:0] frames_sent;

  int          checks;
  int          errors;
  logic [15:0] mlfsr;

  axis_frame_gen #(
    .DATA_WIDTH (32),
    .H_RES      (H_RES),
    .V_RES      (V_RES)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .pattern_sel   (pattern_sel),
    .frame_count   (frame_count),
    .line_gap      (line_gap),
    .frame_gap     (frame_gap),
    .noise_en      (noise_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .frame_done    (frame_done),
    .frames_sent   (frames_sent)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected clean pixel from the pattern definitions.
  function automatic logic [31:0] ref_pix(input int pat, input int x, input int y);
    logic [7:0] v;
    v = 8'(x % 256);
    case (pat)
      0:       return 32'h0080_8080;
      1:       return {8'h00, v, v, v};
      2:       return {8'h00, BARS[x / (H_RES / 8)]};
      default: return (((x / 16) % 2) != ((y / 16) % 2)) ? 32'h00FF_FFFF : 32'h0;
    endcase
  endfunction

  // Reference PRBS: feedback is the XOR of the stages named by the polynomial
  // exponents, counted from the output end of a right-shifting register.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int   taps [4];
    logic fb;
    taps = '{16, 14, 13, 11};
    fb   = 1'b0;
    foreach (taps[i]) fb ^= s[16 - taps[i]];
    return {fb, s[15:1]};
  endfunction

  task automatic check_all_zero(input string where);
    check({where, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({where, "_tlast"},  32'(m_axis_tlast),  32'd0);
    check({where, "_tuser"},  32'(m_axis_tuser),  32'd0);
    check({where, "_busy"},   32'(busy),          32'd0);
    check({where, "_fdone"},  32'(frame_done),    32'd0);
    check({where, "_fsent"},  32'(frames_sent),   32'd0);
    check({where, "_tdata"},  m_axis_tdata,       32'd0);
  endtask

  // Run one enable session and check every cycle against the model.
  // mode: 0 = tready high, 1 = toggling with a 5-cycle stall at line ends,
  // 2 = random. drop_at/rst_at: beat index at which enable falls / reset hits
  // (-1 = never). chg_pat: pattern_sel written when enable falls (-1 = none).
  task automatic stream(input int pat, input int frames, input int lg, input int fg,
                        input int fc, input int mode, input int drop_at,
                        input int chg_pat, input int rst_at, input bit nz);
    int          total, done, gap_left, fs, cyc, stall, stalled_beat, pos, px, py;
    bit          fd, fin, tog, vobs;
    logic [31:0] exp;
    total        = frames * FRAME;
    done         = 0;
    gap_left     = 0;
    fs           = 0;
    cyc          = 0;
    stall        = 0;
    stalled_beat = -1;
    fd           = 1'b0;
    fin          = 1'b0;
    tog          = 1'b1;
    pattern_sel  = 2'(pat);
    line_gap     = 8'(lg);
    frame_gap    = 16'(fg);
    frame_count  = 16'(fc);
    noise_en     = nz;
    enable       = 1'b1;
    while (!fin && cyc < 4000) begin
      @(negedge aclk);
      cyc++;
      pos = done % FRAME;
      px  = pos % H_RES;
      py  = pos / H_RES;
      if (rst_at >= 0 && done == rst_at && gap_left == 0) begin
        areset = 1'b1;
        @(negedge aclk);
        check_all_zero("midreset");
        areset = 1'b0;
        mlfsr  = 16'hACE1;
        fin    = 1'b1;
      end else begin
        vobs = m_axis_tvalid;
        if (done < total && gap_left == 0) begin
          exp = ref_pix(pat, px, py);
`ifdef AXIS_FRAME_GEN_NOISE_EN
          if (nz) exp ^= {8'h00, 5'h00, mlfsr[8:6], 5'h00, mlfsr[5:3], 5'h00, mlfsr[2:0]};
`endif
          check("tvalid_beat", 32'(vobs), 32'd1);
          check("tdata", m_axis_tdata, exp);
          check("tuser", 32'(m_axis_tuser), 32'(pos == 0));
          check("tlast", 32'(m_axis_tlast), 32'(px == H_RES - 1));
          check("busy_run", 32'(busy), 32'd1);
        end else if (gap_left > 0) begin
          check("tvalid_gap", 32'(vobs), 32'd0);
          check("busy_gap", 32'(busy), 32'd1);
          gap_left--;
        end else begin
          check("busy_end", 32'(busy), 32'd0);
          check("tvalid_end", 32'(vobs), 32'd0);
          enable = 1'b0;
          fin    = 1'b1;
        end
        check("frame_done", 32'(frame_done), 32'(fd));
        check("frames_sent", 32'(frames_sent), 32'(fs));
        fd = 1'b0;
        if (!fin) begin
          if (drop_at >= 0 && done >= drop_at) begin
            enable = 1'b0;
            if (chg_pat >= 0) pattern_sel = 2'(chg_pat);
          end
          case (mode)
            0: m_axis_tready = 1'b1;
            1: begin
              if (vobs && px == H_RES - 1 && stalled_beat != done) begin
                stall        = 5;
                stalled_beat = done;
              end
              if (stall > 0) begin
                m_axis_tready = 1'b0;
                stall--;
              end else begin
                m_axis_tready = tog;
                tog           = !tog;
              end
            end
            default: m_axis_tready = 1'($urandom_range(0, 1));
          endcase
          if (vobs && m_axis_tready && done < total) begin
            mlfsr = lfsr_next(mlfsr);
            done++;
            if (pos == FRAME - 1) begin
              gap_left = fg;
              fd       = 1'b1;
              fs++;
            end else if (px == H_RES - 1) begin
              gap_left = lg;
            end
          end
        end
      end
    end
    check("session_timeout", 32'(fin), 32'd1);
    m_axis_tready = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    mlfsr         = 16'hACE1;
    areset        = 1'b1;
    enable        = 1'b0;
    pattern_sel   = 2'd0;
    frame_count   = 16'd0;
    line_gap      = 8'd0;
    frame_gap     = 16'd0;
    noise_en      = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge aclk);
    check_all_zero("reset");
    areset = 1'b0;
    @(negedge aclk);
    check_all_zero("idle");

    // Ramp, one frame, tready held high.
    stream(1, 1, 0, 0, 1, 0, -1, -1, -1, 1'b0);
    // Ramp under toggling backpressure with long stalls on tlast beats.
    stream(1, 1, 0, 0, 1, 1, -1, -1, -1, 1'b0);
    // Line and frame gaps across two frames, random tready.
    stream(2, 2, 3, 10, 2, 2, -1, -1, -1, 1'b0);
    // Continuous mode: pattern switched and enable dropped at beat 20.
    stream(1, 1, 0, 0, 0, 0, 20, 3, -1, 1'b0);
    // Enable falls on the same edge that accepts the last beat of a frame.
    stream(0, 1, 0, 0, 0, 0, FRAME - 1, -1, -1, 1'b0);
    // Continuous with gaps, enable dropped inside the second frame.
    stream(1, 2, 1, 2, 0, 2, FRAME + 36, -1, -1, 1'b0);
    // Reset at beat 30, then a fresh frame from the origin.
    stream(1, 1, 0, 0, 1, 0, -1, -1, 30, 1'b0);
    stream(1, 1, 0, 0, 1, 0, -1, -1, -1, 1'b0);
    // Colour bars with noise requested.
    stream(2, 1, 0, 0, 1, 0, -1, -1, -1, 1'b1);
    stream(2, 1, 2, 3, 1, 2, -1, -1, -1, 1'b1);
    // Randomised sessions.
    for (int r = 0; r < 6; r++) begin
      int f;
      f = int'($urandom_range(1, 2));
      stream(int'($urandom_range(0, 3)), f, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 4)), f, 2, -1, -1, -1, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
